// File: rtl/ram_responder_if.sv
// ram_responder_if -- dcache <-> backing RAM burst interface.
//
// Groups the write-address, write-data, read-address and read-data
// channel signals of the dcache RAM port into one bundle.
//   master : the data cache (initiator) side
//   slave  : the RAM responder side
//
// Signals (widths set by AWIDTH / DWIDTH / LWIDTH):
//   ram_awaddr/ram_awlen/ram_awvalid  initiator -> responder, write burst request
//   ram_awready                       responder -> initiator, one-cycle accept pulse
//   ram_wvalid/ram_wlast              responder -> initiator, write-beat request
//   ram_wready                        initiator -> responder, ready to supply beats
//   ram_wdata                         initiator -> responder, data one cycle after wvalid
//   ram_araddr/ram_arlen/ram_arvalid  initiator -> responder, read burst request
//   ram_arready                       responder -> initiator, one-cycle accept pulse
//   ram_rdata/ram_rvalid/ram_rlast    responder -> initiator, read beat
//   ram_rready                        initiator -> responder, accepts read beat
interface ram_responder_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int LWIDTH = 2
);
  logic [AWIDTH-1:0] ram_awaddr;
  logic [LWIDTH-1:0] ram_awlen;
  logic              ram_awvalid;
  logic              ram_awready;
  logic [DWIDTH-1:0] ram_wdata;
  logic              ram_wvalid;
  logic              ram_wready;
  logic              ram_wlast;
  logic [AWIDTH-1:0] ram_araddr;
  logic [LWIDTH-1:0] ram_arlen;
  logic              ram_arvalid;
  logic              ram_arready;
  logic [DWIDTH-1:0] ram_rdata;
  logic              ram_rvalid;
  logic              ram_rready;
  logic              ram_rlast;

  modport master (
    output ram_awaddr, ram_awlen, ram_awvalid, ram_wdata, ram_wready,
           ram_araddr, ram_arlen, ram_arvalid, ram_rready,
    input  ram_awready, ram_wvalid, ram_wlast, ram_arready,
           ram_rdata, ram_rvalid, ram_rlast
  );

  modport slave (
    input  ram_awaddr, ram_awlen, ram_awvalid, ram_wdata, ram_wready,
           ram_araddr, ram_arlen, ram_arvalid, ram_rready,
    output ram_awready, ram_wvalid, ram_wlast, ram_arready,
           ram_rdata, ram_rvalid, ram_rlast
  );
endinterface

// File: rtl/ram_responder.sv
// ram_responder -- word-addressed backing RAM and burst controller on the
// responder end of the dcache RAM interface.
//
// Accepts one write-back or one allocate burst at a time and paces the data
// beats on both channels: it requests write beats from the initiator
// (ram_wvalid, data returned one cycle later on ram_wdata) and supplies read
// beats (ram_rvalid/ram_rdata/ram_rlast, held while ram_rready is low).
//
// Ports:
//   clk  clock
//   rst  synchronous, active-high reset (memory contents are preserved)
//   ram  ram_responder_if.slave bundle (see rtl/ram_responder_if.sv)
//
// Addressing: word base = addr[log2(DEPTH_WORDS)+1:2]; beat k uses word
// (base+k) mod DEPTH_WORDS. A length of 0 is one beat.
//
// Optional build macro RAM_BURST_GAP_EN: when defined, one idle cycle is
// inserted after every completed beat on both channels.
module ram_responder #(
  parameter int AWIDTH      = 32,
  parameter int DWIDTH      = 32,
  parameter int LWIDTH      = 2,
  parameter int DEPTH_WORDS = 16384,
  parameter int RD_LATENCY  = 2
) (
  input  logic           clk,
  input  logic           rst,
  ram_responder_if.slave ram
);

  localparam int IW   = $clog2(DEPTH_WORDS);
  localparam int LATW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [LATW-1:0] LAT_LAST = (RD_LATENCY > 0) ? LATW'(RD_LATENCY - 1) : '0;

`ifdef RAM_BURST_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    WBEAT,
    WDRAIN,
    RLAT,
    RBEAT
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     base_q, base_d;
  logic [LWIDTH-1:0] nbeats_q, nbeats_d;
  logic [LWIDTH-1:0] k_q, k_d;          // beats issued (write) / loaded (read)
  logic [LWIDTH-1:0] cidx_q, cidx_d;    // write beats captured
  logic [LATW-1:0]   lat_q, lat_d;
  logic              cap_q, cap_d;      // capture wdata this cycle
  logic              awready_q, awready_d;
  logic              arready_q, arready_d;
  logic              wvalid_q, wvalid_d;
  logic              wlast_q, wlast_d;
  logic              rvalid_q, rvalid_d;
  logic              rlast_q, rlast_d;
  logic [DWIDTH-1:0] rdata_q;
  logic              rload;
  logic [IW-1:0]     ridx;
  logic [IW-1:0]     widx;

  logic [DWIDTH-1:0] mem [DEPTH_WORDS];

  // Only the word-index bits of the addresses are meaningful.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ram.ram_awaddr, ram.ram_araddr};

  function automatic logic [LWIDTH-1:0] beats(input logic [LWIDTH-1:0] len);
    return (len == '0) ? LWIDTH'(1) : len;
  endfunction

  assign ridx = base_q + IW'(k_q);
  assign widx = base_q + IW'(cidx_q);

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    nbeats_d  = nbeats_q;
    k_d       = k_q;
    lat_d     = lat_q;
    awready_d = 1'b0;
    arready_d = 1'b0;
    wvalid_d  = 1'b0;
    wlast_d   = 1'b0;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rload     = 1'b0;
    // Every wvalid pulse is followed by exactly one capture cycle.
    cap_d     = wvalid_q;
    cidx_d    = cap_q ? cidx_q + LWIDTH'(1) : cidx_q;

    case (state_q)
      IDLE: begin
        k_d    = '0;
        cidx_d = '0;
        lat_d  = '0;
        if (ram.ram_awvalid) begin
          base_d    = ram.ram_awaddr[IW+1:2];
          nbeats_d  = beats(ram.ram_awlen);
          awready_d = 1'b1;
          state_d   = WBEAT;
        end else if (ram.ram_arvalid) begin
          base_d    = ram.ram_araddr[IW+1:2];
          nbeats_d  = beats(ram.ram_arlen);
          arready_d = 1'b1;
          state_d   = (RD_LATENCY == 0) ? RBEAT : RLAT;
        end
      end

      WBEAT: begin
        if (ram.ram_wready && !(GAP && wvalid_q)) begin
          wvalid_d = 1'b1;
          wlast_d  = (k_q == nbeats_q - LWIDTH'(1));
          k_d      = k_q + LWIDTH'(1);
          if (wlast_d) state_d = WDRAIN;
        end
      end

      // Entered while the final wvalid pulse is on the bus; leave on the
      // cycle that captures it.
      WDRAIN: begin
        if (cap_q && !wvalid_q) state_d = IDLE;
      end

      RLAT: begin
        lat_d = lat_q + LATW'(1);
        if (lat_q == LAT_LAST) state_d = RBEAT;
      end

      RBEAT: begin
        if (rvalid_q && ram.ram_rready) begin
          if (rlast_q) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            state_d  = IDLE;
          end else if (GAP) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
          end else begin
            rload = 1'b1;
          end
        end else if (!rvalid_q) begin
          rload = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (rload) begin
      rvalid_d = 1'b1;
      rlast_d  = (k_q == nbeats_q - LWIDTH'(1));
      k_d      = k_q + LWIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      base_q    <= '0;
      nbeats_q  <= '0;
      k_q       <= '0;
      cidx_q    <= '0;
      lat_q     <= '0;
      cap_q     <= 1'b0;
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      nbeats_q  <= nbeats_d;
      k_q       <= k_d;
      cidx_q    <= cidx_d;
      lat_q     <= lat_d;
      cap_q     <= cap_d;
      awready_q <= awready_d;
      arready_q <= arready_d;
      wvalid_q  <= wvalid_d;
      wlast_q   <= wlast_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      if (rload) rdata_q <= mem[ridx];
    end
  end

  // No reset on the array; a write pending at the reset edge is dropped.
  always_ff @(posedge clk) begin
    if (!rst && cap_q) mem[widx] <= ram.ram_wdata;
  end

  assign ram.ram_awready = awready_q;
  assign ram.ram_arready = arready_q;
  assign ram.ram_wvalid  = wvalid_q;
  assign ram.ram_wlast   = wlast_q;
  assign ram.ram_rvalid  = rvalid_q;
  assign ram.ram_rlast   = rlast_q;
  assign ram.ram_rdata   = rdata_q;

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder -- self-checking bench for ram_responder.
// Drives write/read bursts through the interface, keeps a word model of the
// RAM, pushes expected read beats to a queue when a read is requested and
// pops/compares them as beats complete.
module tb_ram_responder;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LW    = 2;
  localparam int DEPTH = 16384;
  localparam int RDLAT = 2;

`ifdef RAM_BURST_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_responder_if #(.AWIDTH(AW), .DWIDTH(DW), .LWIDTH(LW)) bus ();

  ram_responder #(
    .AWIDTH(AW), .DWIDTH(DW), .LWIDTH(LW),
    .DEPTH_WORDS(DEPTH), .RD_LATENCY(RDLAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ram(bus)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
  } rexp_t;

  rexp_t       exp_q[$];
  logic [31:0] model [int unsigned];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          t_aw  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_awready"}, bus.ram_awready, 0);
    chk({tag, "_arready"}, bus.ram_arready, 0);
    chk({tag, "_wvalid"},  bus.ram_wvalid,  0);
    chk({tag, "_wlast"},   bus.ram_wlast,   0);
    chk({tag, "_rvalid"},  bus.ram_rvalid,  0);
    chk({tag, "_rlast"},   bus.ram_rlast,   0);
    chk({tag, "_rdata"},   bus.ram_rdata,   0);
  endtask

  // Called just after a negedge. wstall = cycles with wready low at start.
  task automatic do_write(input logic [31:0] addr, input logic [1:0] len,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input int wstall);
    logic [31:0] d [3];
    int          n, pulses, caps;
    int unsigned base;
    bit          prev, got;
    d[0] = d0; d[1] = d1; d[2] = d2;
    n    = (len == 0) ? 1 : int'(len);
    base = (addr >> 2) & (DEPTH - 1);
    for (int k = 0; k < n; k++) model[(base + k) & (DEPTH - 1)] = d[k];

    bus.ram_wready  = (wstall == 0);
    bus.ram_awaddr  = addr;
    bus.ram_awlen   = len;
    bus.ram_awvalid = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (bus.ram_awready) got = 1'b1;
    end
    chk("awready_seen", got, 1);
    t_aw = cyc;
    bus.ram_awvalid = 1'b0;

    pulses = 0; caps = 0; prev = 1'b0;
    for (int c = 1; c <= 60 && caps < n; c++) begin
      @(negedge clk);
      // data for a pulse is presented through the whole following cycle
      if (prev) begin
        bus.ram_wdata = d[caps];
        caps++;
      end
      prev = bus.ram_wvalid;
      if (c <= wstall) chk("wstall_novalid", bus.ram_wvalid, 0);
      if (c == wstall) bus.ram_wready = 1'b1;
      if (bus.ram_wvalid) begin
        chk("wlast", bus.ram_wlast, (pulses == n - 1));
        pulses++;
      end
    end
    chk("wpulses", pulses, n);
  endtask

  // exp_dist >= 0 checks cycles from the last awready to arready.
  task automatic do_read(input logic [31:0] addr, input logic [1:0] len,
                         input int stall_beat, input int stall_n,
                         input bit abort, input bit pre_issued, input int exp_dist);
    int          n, beat, stalls, t_ar;
    int unsigned base;
    bit          seen, got, gapchk;
    rexp_t       e;
    n    = (len == 0) ? 1 : int'(len);
    base = (addr >> 2) & (DEPTH - 1);
    for (int k = 0; k < n; k++) begin
      e.data = model[(base + k) & (DEPTH - 1)];
      e.last = (k == n - 1);
      exp_q.push_back(e);
    end
    if (!pre_issued) begin
      bus.ram_araddr  = addr;
      bus.ram_arlen   = len;
      bus.ram_arvalid = 1'b1;
    end
    bus.ram_rready = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (bus.ram_arready) got = 1'b1;
    end
    chk("arready_seen", got, 1);
    t_ar = cyc;
    bus.ram_arvalid = 1'b0;
    if (exp_dist >= 0) chk("aw_to_ar_cycles", t_ar - t_aw, exp_dist);

    beat = 0; stalls = 0; seen = 1'b0; gapchk = 1'b0;
    for (int c = 0; c < 60 && beat < n; c++) begin
      @(negedge clk);
      if (gapchk) begin
        chk("rbeat_gap", bus.ram_rvalid, GAP ? 0 : 1);
        gapchk = 1'b0;
      end
      if (bus.ram_rvalid) begin
        if (!seen) begin
          seen = 1'b1;
          chk("rd_latency", cyc - t_ar, RDLAT + 1);
          if (abort) begin
            rst = 1'b1;
            @(negedge clk);
            chk_idle_outputs("rst_mid");
            rst = 1'b0;
            exp_q.delete();
            return;
          end
        end
        if (beat == stall_beat && stalls < stall_n) begin
          bus.ram_rready = 1'b0;
          stalls++;
          chk("stall_rdata", bus.ram_rdata, exp_q[0].data);
          chk("stall_rlast", bus.ram_rlast, exp_q[0].last);
        end else begin
          bus.ram_rready = 1'b1;
          e = exp_q.pop_front();
          chk("rdata", bus.ram_rdata, e.data);
          chk("rlast", bus.ram_rlast, e.last);
          beat++;
          if (beat < n) gapchk = 1'b1;
        end
      end
    end
    chk("rbeats", beat, n);
    @(negedge clk);
    chk("rvalid_drop", bus.ram_rvalid, 0);
    chk("rlast_drop", bus.ram_rlast, 0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.ram_awaddr  = '0;
    bus.ram_awlen   = '0;
    bus.ram_awvalid = 1'b0;
    bus.ram_wdata   = '0;
    bus.ram_wready  = 1'b1;
    bus.ram_araddr  = '0;
    bus.ram_arlen   = '0;
    bus.ram_arvalid = 1'b0;
    bus.ram_rready  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // basic write then read back
    do_write(32'h100, 2'd2, 32'hAAAA0001, 32'hAAAA0002, 32'h0, 0);
    do_read(32'h100, 2'd2, -1, 0, 1'b0, 1'b0, -1);

    // unaligned read after preloading words 0x40/0x41 (wready stalled first)
    do_write(32'h100, 2'd2, 32'h11111111, 32'h22222222, 32'h0, 2);
    do_read(32'h103, 2'd2, -1, 0, 1'b0, 1'b0, -1);

    // simultaneous aw/ar: write wins, read sees new data after drain
    bus.ram_araddr  = 32'h200;
    bus.ram_arlen   = 2'd3;
    bus.ram_arvalid = 1'b1;
    do_write(32'h200, 2'd3, 32'hB0000001, 32'hB0000002, 32'hB0000003, 0);
    do_read(32'h200, 2'd3, -1, 0, 1'b0, 1'b1, GAP ? 2 * 3 + 2 : 3 + 3);

    // length 0 means one beat
    do_write(32'h300, 2'd0, 32'hCAFE0000, 32'h0, 32'h0, 0);
    do_read(32'h300, 2'd0, -1, 0, 1'b0, 1'b0, -1);

    // rready low for 3 cycles on beat 1
    do_read(32'h100, 2'd2, 0, 3, 1'b0, 1'b0, -1);

    // wrap at top of memory, both directions
    do_write((DEPTH - 1) * 4, 2'd2, 32'h5555AAAA, 32'h6666BBBB, 32'h0, 0);
    do_read((DEPTH - 1) * 4, 2'd2, -1, 0, 1'b0, 1'b0, -1);

    // reset during first read beat, then memory is intact
    do_read(32'h100, 2'd2, -1, 0, 1'b1, 1'b0, -1);
    @(negedge clk);
    do_read(32'h100, 2'd2, -1, 0, 1'b0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Word-addressed backing RAM model and controller on the responder end of the dcache RAM interface. It accepts one write-back or one allocate burst at a time.
- It drives the data-beat pacing on both channels: it requests write beats from the initiator and supplies read beats to it.
- It sits between the data cache and main memory in the core's memory subsystem.

Parameters:
AWIDTH, 32, address width (byte address).
DWIDTH, 32, data width; one word per beat.
LWIDTH, 2, burst length field width; the value is a beat count, not count-1.
DEPTH_WORDS, 16384, memory depth in words; must be a power of two.
RD_LATENCY, 2, idle cycles between the arready pulse and the first rvalid (0 allowed).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ram_awaddr  in  AWIDTH  write burst byte address
ram_awlen  in  LWIDTH  write beat count
ram_awvalid  in  1  write address valid
ram_awready  out  1  write address accept pulse
ram_wdata  in  DWIDTH  write beat data, valid the cycle after its ram_wvalid pulse
ram_wvalid  out  1  request for one write beat
ram_wready  in  1  initiator ready to supply write beats
ram_wlast  out  1  marks final write-beat request
ram_araddr  in  AWIDTH  read burst byte address
ram_arlen  in  LWIDTH  read beat count
ram_arvalid  in  1  read address valid
ram_arready  out  1  read address accept pulse
ram_rdata  out  DWIDTH  read beat data
ram_rvalid  out  1  read beat valid
ram_rready  in  1  initiator accepts read beat
ram_rlast  out  1  marks final read beat

Behaviour:
- Reset (rst high at a clk edge):
  - All outputs go to 0 and the state goes to IDLE.
  - Beat counters, latency counter and the capture-pending flag are cleared.
  - Memory contents are preserved.
  - Reset mid-burst abandons the burst; no partial write completes after the reset edge.
- Address decode:
  - base = addr[log2(DEPTH_WORDS)+1:2]; the low two bits and the upper bits are ignored, so unaligned addresses round down.
  - Beat k uses word (base+k) mod DEPTH_WORDS (wraps).
  - A length of 0 is treated as 1 beat. Maximum is 2^LWIDTH-1 beats.
- States: IDLE, WBEAT, WDRAIN, RLAT, RBEAT.
- IDLE:
  - If ram_awvalid: latch awaddr/awlen, pulse ram_awready for exactly one cycle (registered, so it is asserted the cycle after awvalid is sampled), then go to WBEAT.
  - Else if ram_arvalid: latch araddr/arlen, pulse ram_arready for one cycle, then go to RLAT (or to RBEAT if RD_LATENCY=0).
  - Simultaneous awvalid and arvalid: write wins. The read is accepted only after returning to IDLE.
  - At least one IDLE cycle is spent between bursts. Valid signals sampled on the awready/arready pulse cycle are not re-accepted.
- WBEAT:
  - Each cycle with ram_wready=1, assert ram_wvalid for beat k. ram_wlast is high on the final beat only.
  - With ram_wready=0, ram_wvalid=0 and k does not advance.
  - Data for beat k is sampled from ram_wdata on the cycle after its wvalid pulse and written to mem[base+k] at that cycle's edge. Captures pipeline under back-to-back pulses.
  - After the last pulse, go to WDRAIN.
- WDRAIN: capture the final beat, then return to IDLE. A write of N beats occupies N+1 cycles after the awready pulse when wready is held high.
- RLAT: count RD_LATENCY cycles, then go to RBEAT.
- RBEAT:
  - ram_rvalid=1, ram_rdata=mem[base+k], ram_rlast=(k==N-1).
  - A beat completes on a cycle with rvalid and rready both high; k then increments.
  - With rready=0, rdata, rvalid and rlast hold stable.
  - After the last beat completes: rvalid=0, rlast=0, go to IDLE.
- Write-then-read to the same word always returns the new data, because a write fully drains before any read is accepted.
- Outputs not active in the current state are held at 0. ram_rdata holds its last value.

Optional Feature:
- Macro RAM_BURST_GAP_EN.
- Defined:
  - One mandatory idle cycle after every completed beat on both channels: wvalid low for one cycle between write-beat pulses, and rvalid low for one cycle between read beats.
  - Write-data capture still samples exactly one cycle after its own pulse.
  - Used to stress initiator beat counting.
- Undefined: beats are back-to-back as described above.

Test Plan:
1. awaddr=0x100, awlen=2; initiator returns 0xAAAA0001 and 0xAAAA0002 → two wvalid pulses, wlast on the 2nd. Then araddr=0x100, arlen=2 → rdata 0xAAAA0001 then 0xAAAA0002, rlast on beat 2, first rvalid RD_LATENCY cycles after arready.
2. araddr=0x103, arlen=2 after preloading words 0x40=0x11111111 and 0x41=0x22222222 → beats 0x11111111 and 0x22222222.
3. awvalid and arvalid both high in the same cycle → awready pulses first. arready pulses only after WDRAIN, and the read returns the newly written data.
4. Read len 2 with rready low for 3 cycles during beat 1 → rvalid, rdata and rlast stay constant; beat 2 follows the first cycle in which rready is high.
5. araddr=(DEPTH_WORDS-1)*4, arlen=2 → beat 1 is the last word, beat 2 is word 0 (wrap).
6. rst pulsed during RBEAT beat 1 → all outputs 0 after the edge, state IDLE. A subsequent read of the same address returns unchanged memory.
